// File: rtl/conv_sched.sv
// rtl/conv_sched.sv - 3x3 kernel over 5x5 map, one output per position, optional ReLU via CONV_SCHED_RELU_EN
module conv_sched #(
    parameter int OUT_W = 20
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [199:0]            f_in,
    input  logic [71:0]             w_in,
    output logic signed [OUT_W-1:0] out_data,
    output logic [1:0]              out_row,
    output logic [1:0]              out_col,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {IDLE, CALC, OUT, FIN} state_t;

    state_t                  state, state_nxt;
    logic [199:0]            f_reg;
    logic [71:0]             w_reg;
    logic [1:0]              kr;
    logic signed [OUT_W-1:0] acc, acc_nxt, result;
    logic signed [17:0]      dot;
    logic signed [7:0]       fe, we;
    logic signed [15:0]      prod;
    logic                    last_pos;

    assign last_pos = (out_row == 2'd2) && (out_col == 2'd2);

    // One kernel row against feature row (row+kr), columns col..col+2
    always_comb begin
        dot  = '0;
        fe   = '0;
        we   = '0;
        prod = '0;
        for (int j = 0; j < 3; j++) begin
            fe   = f_reg[((int'(out_row) + int'(kr)) * 5 + int'(out_col) + j) * 8 +: 8];
            we   = w_reg[(int'(kr) * 3 + j) * 8 +: 8];
            prod = fe * we;
            dot  = dot + {{2{prod[15]}}, prod};
        end
        acc_nxt = acc + {{(OUT_W-18){dot[17]}}, dot};
`ifdef CONV_SCHED_RELU_EN
        result = acc_nxt[OUT_W-1] ? '0 : acc_nxt;
`else
        result = acc_nxt;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = CALC;
            end
            CALC: begin
                if (kr == 2'd2) state_nxt = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = last_pos ? FIN : CALC;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_reg    <= '0;
            w_reg    <= '0;
            kr       <= '0;
            acc      <= '0;
            out_data <= '0;
            out_row  <= '0;
            out_col  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        f_reg   <= f_in;
                        w_reg   <= w_in;
                        kr      <= '0;
                        acc     <= '0;
                        out_row <= '0;
                        out_col <= '0;
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    if (kr == 2'd2) begin
                        kr       <= '0;
                        out_data <= result;
                    end else begin
                        kr <= kr + 2'd1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        acc <= '0;
                        kr  <= '0;
                        if (out_col == 2'd2) begin
                            out_col <= '0;
                            out_row <= (out_row == 2'd2) ? 2'd0 : out_row + 2'd1;
                        end else begin
                            out_col <= out_col + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_sched.sv
// tb/tb_conv_sched.sv - randomized frames checked against an arithmetic convolution model
module tb_conv_sched;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [199:0]       f_in;
    logic [71:0]        w_in;
    logic signed [19:0] out_data;
    logic [1:0]         out_row, out_col;
    logic               out_valid, out_ready, busy, done;

    int vectors = 0;
    int miscompares = 0;
    int cyc;
    int fa[25];
    int wa[9];

    conv_sched dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .f_in     (f_in),
        .w_in     (w_in),
        .out_data (out_data),
        .out_row  (out_row),
        .out_col  (out_col),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic int model(int r, int c);
        int s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += fa[(r + i) * 5 + c + j] * wa[i * 3 + j];
`ifdef CONV_SCHED_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic load();
        for (int k = 0; k < 25; k++) f_in[k*8 +: 8] = 8'(fa[k]);
        for (int k = 0; k < 9; k++)  w_in[k*8 +: 8] = 8'(wa[k]);
    endtask

    task automatic rand_ops();
        for (int k = 0; k < 25; k++) fa[k] = int'($urandom_range(0, 255)) - 128;
        for (int k = 0; k < 9; k++)  wa[k] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic run_frame(input int stall_idx, input bit poke, input int abort_idx);
        int n;
        load();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        chk("busy_after_start", busy, 1);
        for (int k = 0; k < 25; k++) f_in[k*8 +: 8] = 8'($urandom);
        for (int k = 0; k < 9; k++)  w_in[k*8 +: 8] = 8'($urandom);
        for (int k = 0; k < 9; k++) begin
            n = 0;
            while (!out_valid && n < 20) begin
                start = poke && (k == 1) && (n == 0);
                tick();
                n++;
                start = 1'b0;
                if (k == abort_idx && n == 1) begin
                    reset = 1'b0;
                    #1;
                    chk("abort_valid", out_valid, 0);
                    chk("abort_busy", busy, 0);
                    chk("abort_done", done, 0);
                    chk("abort_data", out_data, 0);
                    repeat (2) tick();
                    reset = 1'b1;
                    repeat (3) begin
                        tick();
                        chk("abort_no_done", {done, busy}, 0);
                    end
                    return;
                end
            end
            chk("latency", n, 3);
            chk("data", out_data, model(k / 3, k % 3));
            chk("row", out_row, k / 3);
            chk("col", out_col, k % 3);
            if (k == stall_idx) begin
                out_ready = 1'b0;
                repeat (10) tick();
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, model(k / 3, k % 3));
                chk("stall_pos", {out_row, out_col}, {2'(k / 3), 2'(k % 3)});
                out_ready = 1'b1;
            end
            tick();
            if (k < 8) chk("valid_drop", out_valid, 0);
        end
        chk("done_pulse", done, 1);
        chk("frame_cycles", cyc, (stall_idx >= 0) ? 46 : 36);
        chk("busy_fin", busy, 1);
        start = poke;
        tick();
        start = 1'b0;
        chk("done_clear", done, 0);
        chk("idle_busy", busy, 0);
        tick();
        chk("fin_start_ignored", busy, 0);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        f_in = '0;
        w_in = '0;
        cyc = 0;
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_data", out_data, 0);
        chk("rst_pos", {out_row, out_col}, 0);
        reset = 1'b1;
        repeat (2) tick();
        chk("idle_hold", busy, 0);

        foreach (fa[k]) fa[k] = 1;
        foreach (wa[k]) wa[k] = 1;
        run_frame(-1, 1'b0, -1);

        foreach (fa[k]) fa[k] = k;
        foreach (wa[k]) wa[k] = (k % 4 == 0) ? 1 : 0;
        run_frame(-1, 1'b0, -1);

        foreach (fa[k]) fa[k] = -128;
        foreach (wa[k]) wa[k] = -128;
        run_frame(-1, 1'b0, -1);

        foreach (wa[k]) wa[k] = 127;
        run_frame(-1, 1'b0, -1);

        rand_ops();
        run_frame(4, 1'b0, -1);

        rand_ops();
        run_frame(-1, 1'b1, -1);

        rand_ops();
        run_frame(-1, 1'b0, 3);
        rand_ops();
        run_frame(-1, 1'b0, -1);

        for (int t = 0; t < 3; t++) begin
            rand_ops();
            run_frame(-1, 1'b0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/conv_sched.md
CONV_SCHED -- requirements
Module: conv_sched

Interface
REQ-001 Parameter OUT_W, default 20, width of the signed accumulator and out_data (legal range 20..32).
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low; reset=0 clears all state immediately.
REQ-004 start  in  1  frame request; sampled only in IDLE.
REQ-005 f_in  in  200  5x5 signed 8-bit feature map; element (r,c) at bits [(r*5+c)*8 +: 8].
REQ-006 w_in  in  72  3x3 signed 8-bit kernel; element (i,j) at bits [(i*3+j)*8 +: 8].
REQ-007 out_data  out  OUT_W  signed convolution result for the current position.
REQ-008 out_row, out_col  out  2 each  output position, 0..2.
REQ-009 out_valid  out  1  out_data, out_row and out_col are valid.
REQ-010 out_ready  in  1  consumer accepts the output; transfer occurs when out_valid=1 and out_ready=1.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 done  out  1  one-cycle pulse after the ninth output transfers.

Function
REQ-013 States are IDLE, CALC, OUT and FIN.
REQ-014 IDLE with start=1: f_in and w_in are captured into internal registers, position and kernel row are set to (0,0,0), the accumulator is cleared, and the FSM moves to CALC; start=0 holds IDLE.
REQ-015 CALC: each cycle adds the signed 3-tap dot product of feature row (r+kr), columns c..c+2, with kernel row kr to the accumulator; kr advances 0->1->2, and after kr=2 the FSM moves to OUT.
REQ-016 out_valid rises exactly 3 clk edges after the edge that accepted start, or after the edge of the previous transfer.
REQ-017 OUT: out_valid=1; out_data, out_row and out_col are held stable while out_ready=0, for an unbounded number of cycles.
REQ-018 On an OUT transfer, out_valid drops on the next edge, and the position advances row-major (c increments; c=2 wraps to 0 with r incrementing).
REQ-019 After a transfer, the accumulator and kr are cleared and the FSM returns to CALC, unless the transferred position was (2,2), in which case it goes to FIN.
REQ-020 FIN lasts one cycle with done=1, then returns to IDLE; busy=0 from that IDLE cycle onward.
REQ-021 Products are signed 8x8->16; sums are sign-extended to OUT_W. Overflow is impossible at OUT_W>=20 (max |sum| 147456); no wrap or saturation logic is present.
REQ-022 start while busy=1 is ignored, including in FIN; changes to f_in and w_in after capture have no effect on the frame in progress.
REQ-023 Minimum frame time with out_ready held at 1: 36 cycles from the start edge to the done pulse.

Reset
REQ-024 reset=0 asynchronously forces IDLE, out_valid=0, done=0, busy=0, out_data=0, out_row=0, out_col=0, and clears the accumulator, kr and the captured operands.
REQ-025 reset asserted mid-frame abandons the frame with no done pulse; after reset deasserts, a new start is required.

Configuration
REQ-026 Macro CONV_SCHED_RELU_EN defined: on entry to OUT, negative results are presented as 0 (ReLU); non-negative results are unchanged.
REQ-027 CONV_SCHED_RELU_EN undefined: out_data is the raw signed sum; no other behaviour differs.

Verification
REQ-028 All f=1, all w=1, out_ready=1 -> nine outputs of 9, positions (0,0)..(2,2) row-major, done at cycle 36.
REQ-029 f(r,c)=r*5+c, w=identity (w(0,0)=w(1,1)=w(2,2)=1, others 0) -> outputs 18,21,24,33,36,39,48,51,54.
REQ-030 All f=-128, all w=-128 -> every output is 147456; all f=-128, all w=127 -> every output is -146304, or 0 with CONV_SCHED_RELU_EN defined.
REQ-031 out_ready held 0 for 10 cycles at position (1,1) -> out_valid and data stay stable, no position skipped, done delayed by 10 cycles.
REQ-032 start pulsed during CALC and during FIN -> ignored; operands unchanged; exactly nine outputs and one done.
REQ-033 reset=0 asserted mid-CALC at position (1,0) -> out_valid=0 and busy=0 immediately; no done; a subsequent start produces a full correct frame.
